multi_phase_traffic_controller: RTL and testbench

//  N-phase intersection controller; successor to the fixed two-road controller.

---
 rtl/tc_pkg.sv | 20 ++
 rtl/tc_interval_timer.sv | 35 +++
 rtl/multi_phase_traffic_controller.sv | 189 ++++++++++++++++++
 tb/tb_multi_phase_traffic_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and constants for the multi-phase traffic controller.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_WALK   = 2'd3
    } tc_state_t;

    localparam logic [1:0] SEL_GREEN  = 2'd0;
    localparam logic [1:0] SEL_EXT    = 2'd1;
    localparam logic [1:0] SEL_YELLOW = 2'd2;
    localparam logic [1:0] SEL_NONE   = 2'd3;

    localparam int DEF_GREEN_S  = 6;
    localparam int DEF_EXT_S    = 3;
    localparam int DEF_YELLOW_S = 2;

endpackage

// File: rtl/tc_interval_timer.sv
// Seconds prescaler plus down-counter; expired pulses in the last cycle of an interval.
module tc_interval_timer #(
    parameter int TIME_W        = 4,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic              clk,
    input  logic              load,
    input  logic [TIME_W-1:0] value,
    output logic              expired
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PRE_W-1:0]  presc;
    logic [TIME_W-1:0] count;
    logic              tick;

    assign tick    = (presc == PRE_W'(TICKS_PER_SEC - 1));
    assign expired = tick && (count == TIME_W'(1));

    always_ff @(posedge clk) begin
        if (load) begin
            presc <= '0;
            count <= value;
        end else if (tick) begin
            presc <= '0;
            if (count != '0) begin
                count <= count - TIME_W'(1);
            end
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// N-phase intersection controller: demand skipping, one-shot green extension,
// end-of-cycle pedestrian walk and a runtime-programmable duration table.
module multi_phase_traffic_controller
    import tc_pkg::*;
#(
    parameter int NUM_PHASES    = 4,
    parameter int TIME_W        = 4,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int WALK_TIME     = 3,
    parameter int ALLRED_TIME   = 1,
    localparam int PH_W         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] sensor,
    input  logic                  walk_request,
    input  logic                  reprogram,
    input  logic [PH_W-1:0]       prog_phase,
    input  logic [1:0]            prog_sel,
    input  logic [TIME_W-1:0]     prog_value,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic                  walk,
    output logic [PH_W-1:0]       cur_phase
);

    tc_state_t             state, state_n;
    logic [PH_W-1:0]       phase, phase_n, nxt_phase;
    logic                  ext_taken, ext_taken_n, nxt_found;
    logic [NUM_PHASES-1:0] demand, clr_mask;
    logic                  walk_lat, walk_done;
    logic                  ld, expired;
    logic [TIME_W-1:0]     ld_val, wr_val;
    logic [31:0]           prog_phase_ext;
    logic [NUM_PHASES-1:0] lamp_g, lamp_y;
    logic                  lamp_w;

    logic [TIME_W-1:0] green_tbl [NUM_PHASES];
    logic [TIME_W-1:0] ext_tbl   [NUM_PHASES];
    logic [TIME_W-1:0] yel_tbl   [NUM_PHASES];

    tc_interval_timer #(
        .TIME_W        (TIME_W),
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_timer (
        .clk     (clk),
        .load    (reset || ld),
        .value   (reset ? TIME_W'(DEF_GREEN_S) : ld_val),
        .expired (expired)
    );

    // Duration table; zero is clamped to one second except for the extension.
    assign prog_phase_ext = 32'(prog_phase);
    assign wr_val         = (prog_value == '0) ? TIME_W'(1) : prog_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                green_tbl[i] <= TIME_W'(DEF_GREEN_S);
                ext_tbl[i]   <= TIME_W'(DEF_EXT_S);
                yel_tbl[i]   <= TIME_W'(DEF_YELLOW_S);
            end
        end else if (reprogram && prog_sel != SEL_NONE && prog_phase_ext < NUM_PHASES) begin
            case (prog_sel)
                SEL_GREEN:  green_tbl[prog_phase] <= wr_val;
                SEL_EXT:    ext_tbl[prog_phase]   <= prog_value;
                SEL_YELLOW: yel_tbl[prog_phase]   <= wr_val;
                default:    ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        ext_taken_n = ext_taken;
        ld          = 1'b0;
        ld_val      = '0;
        clr_mask    = '0;
        nxt_found   = 1'b0;
        nxt_phase   = '0;
        // Descending scan so the lowest later phase with demand wins.
        for (int i = NUM_PHASES - 1; i >= 1; i--) begin
            if (i > int'(phase) && demand[i]) begin
                nxt_found = 1'b1;
                nxt_phase = PH_W'(i);
            end
        end
        case (state)
            ST_GREEN: begin
                if (expired) begin
                    if (sensor[phase] && !ext_taken && ext_tbl[phase] != '0) begin
                        ext_taken_n = 1'b1;
                        ld          = 1'b1;
                        ld_val      = ext_tbl[phase];
                    end else begin
                        state_n = ST_YELLOW;
                        ld      = 1'b1;
                        ld_val  = yel_tbl[phase];
                    end
                end
            end
            ST_YELLOW: begin
                if (expired) begin
                    state_n = ST_ALLRED;
                    ld      = 1'b1;
                    ld_val  = TIME_W'(ALLRED_TIME);
                end
            end
            ST_ALLRED: begin
                if (expired) begin
                    if (nxt_found) begin
                        state_n = ST_GREEN;
                        phase_n = nxt_phase;
                    end else if (walk_lat) begin
                        state_n = ST_WALK;
                        ld      = 1'b1;
                        ld_val  = TIME_W'(WALK_TIME);
                    end else begin
                        state_n = ST_GREEN;
                        phase_n = '0;
                    end
                end
            end
            ST_WALK: begin
                if (expired) begin
                    state_n = ST_GREEN;
                    phase_n = '0;
                end
            end
            default: state_n = ST_GREEN;
        endcase
        if (state_n == ST_GREEN && state != ST_GREEN) begin
            ext_taken_n        = 1'b0;
            ld                 = 1'b1;
            ld_val             = green_tbl[phase_n];
            clr_mask[phase_n]  = 1'b1;
        end
    end

    assign walk_done = (state == ST_WALK) && expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_GREEN;
            phase     <= '0;
            ext_taken <= 1'b0;
            demand    <= '0;
            walk_lat  <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            ext_taken <= ext_taken_n;
            demand    <= (demand & ~clr_mask) | sensor;
            walk_lat  <= (walk_lat & ~walk_done) | walk_request;
        end
    end

    // Lamps are registered from the next state so they move with the state register.
    always_comb begin
        lamp_g = '0;
        lamp_y = '0;
        lamp_w = 1'b0;
        case (state_n)
            ST_GREEN:  lamp_g[phase_n] = 1'b1;
            ST_YELLOW: lamp_y[phase_n] = 1'b1;
            ST_WALK:   lamp_w          = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            green  <= NUM_PHASES'(1);
            yellow <= '0;
            red    <= ~NUM_PHASES'(1);
            walk   <= 1'b0;
        end else begin
            green  <= lamp_g;
            yellow <= lamp_y;
            red    <= ~(lamp_g | lamp_y);
            walk   <= lamp_w;
        end
    end

    assign cur_phase = phase;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Scoreboard bench: expected lamp segments (pattern, length in cycles) are queued
// with the stimulus and compared against segments observed on the outputs.
module tb_multi_phase_traffic_controller;

    localparam int NP  = 4;
    localparam int TPS = 4;

    typedef struct packed {
        logic [12:0] sig;
        int          len;
    } seg_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NP-1:0] sensor = '0;
    logic          walk_request = 1'b0;
    logic          reprogram = 1'b0;
    logic [1:0]    prog_phase = '0;
    logic [1:0]    prog_sel = '0;
    logic [3:0]    prog_value = '0;
    logic [NP-1:0] red, yellow, green;
    logic          walk;
    logic [1:0]    cur_phase;

    int   checks = 0;
    int   errors = 0;
    bit   started = 0;
    seg_t obs_q[$];
    seg_t exp_q[$];

    multi_phase_traffic_controller #(
        .NUM_PHASES    (NP),
        .TIME_W        (4),
        .TICKS_PER_SEC (TPS),
        .WALK_TIME     (3),
        .ALLRED_TIME   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .walk_request (walk_request),
        .reprogram    (reprogram),
        .prog_phase   (prog_phase),
        .prog_sel     (prog_sel),
        .prog_value   (prog_value),
        .red          (red),
        .yellow       (yellow),
        .green        (green),
        .walk         (walk),
        .cur_phase    (cur_phase)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic w, input logic [3:0] g, input logic [3:0] y);
        return {w, ~(g | y), y, g};
    endfunction
    function automatic logic [12:0] sg(input int p);
        return mk(1'b0, 4'(1 << p), 4'b0);
    endfunction
    function automatic logic [12:0] sy(input int p);
        return mk(1'b0, 4'b0, 4'(1 << p));
    endfunction
    function automatic logic [12:0] sar();
        return mk(1'b0, 4'b0, 4'b0);
    endfunction
    function automatic logic [12:0] swk();
        return mk(1'b1, 4'b0, 4'b0);
    endfunction

    // Segment monitor: one entry per run of identical lamp outputs.
    logic [12:0] msig;
    int          mlen;
    bit          have = 0;
    always @(negedge clk) begin
        logic [12:0] cur;
        seg_t s;
        cur = {walk, red, yellow, green};
        if (reset) begin
            have = 0;
        end else if (!have) begin
            have = 1; msig = cur; mlen = 1;
        end else if (cur === msig) begin
            mlen++;
        end else begin
            s.sig = msig; s.len = mlen;
            obs_q.push_back(s);
            msig = cur; mlen = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (!$onehot0(green | yellow) || (walk && |(green | yellow))) begin
                errors++;
                $display("FAIL invariant t=%0t green=%b yellow=%b walk=%b", $time, green, yellow, walk);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [12:0] sig, input int len);
        seg_t s;
        s.sig = sig; s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; sensor = '0; walk_request = 1'b0; reprogram = 1'b0;
        obs_q.delete(); exp_q.delete();
        cyc(2);
        reset = 1'b0;
        started = 1;
    endtask

    task automatic wait_obs(output bit ok);
        for (int k = 0; k < 2000 && obs_q.size() < exp_q.size(); k++) @(posedge clk);
        #1;
        ok = (obs_q.size() >= exp_q.size());
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (green !== 4'b0001) begin errors++; $display("FAIL rst_green got=%b want=0001", green); end
        checks++; if (red !== 4'b1110) begin errors++; $display("FAIL rst_red got=%b want=1110", red); end
        checks++; if (yellow !== 4'b0000) begin errors++; $display("FAIL rst_yellow got=%b want=0000", yellow); end
        checks++; if (walk !== 1'b0) begin errors++; $display("FAIL rst_walk got=%b want=0", walk); end
        checks++; if (cur_phase !== 2'd0) begin errors++; $display("FAIL rst_phase got=%0d want=0", cur_phase); end
    endtask

    task automatic test_idle_cycle();
        bit ok; seg_t e, o; int n = 0;
        apply_reset();
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4);
        push_exp(sg(0), 24); push_exp(sy(0), 8);
        wait_obs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL idle_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL idle_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    task automatic test_skip();
        bit ok; seg_t e, o; int n = 0;
        apply_reset();
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4);
        push_exp(sg(2), 24); push_exp(sy(2), 8); push_exp(sar(), 4); push_exp(sg(0), 24);
        cyc(5); sensor[2] = 1'b1; cyc(1); sensor[2] = 1'b0;
        wait_obs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL skip_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL skip_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    task automatic test_extension();
        bit ok; seg_t e, o; int n = 0;
        apply_reset();
        sensor[0] = 1'b1;
        push_exp(sg(0), 36); push_exp(sy(0), 8); push_exp(sar(), 4); push_exp(sg(0), 36);
        wait_obs(ok);
        sensor[0] = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL ext_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ext_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    task automatic test_walk();
        bit ok; seg_t e, o; int n = 0;
        apply_reset();
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4); push_exp(swk(), 12);
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4); push_exp(sg(0), 24);
        cyc(5); walk_request = 1'b1; cyc(1); walk_request = 1'b0;
        wait_obs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL walk_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL walk_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    task automatic test_reprogram();
        bit ok, found; seg_t e, o; int n = 0;
        apply_reset();
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4);
        push_exp(sg(1), 24); push_exp(sy(1), 8); push_exp(sar(), 4);
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4);
        push_exp(sg(1), 24); push_exp(sy(1), 20); push_exp(sar(), 4);
        cyc(3); sensor[1] = 1'b1; cyc(1); sensor[1] = 1'b0;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            cyc(1);
            found = (yellow[1] === 1'b1);
        end
        checks++; if (!found) begin errors++; $display("FAIL prog_y1_seen got=0 want=1"); end
        cyc(2);
        reprogram = 1'b1; prog_phase = 2'd1; prog_sel = 2'd2; prog_value = 4'd5; sensor[1] = 1'b1;
        cyc(1);
        reprogram = 1'b0; sensor[1] = 1'b0;
        wait_obs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL prog_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL prog_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    task automatic test_prog_zero();
        bit ok; seg_t e, o; int n = 0;
        apply_reset();
        sensor[0] = 1'b1;
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4);
        push_exp(sg(0), 4); push_exp(sy(0), 8);
        reprogram = 1'b1; prog_phase = 2'd0; prog_sel = 2'd1; prog_value = 4'd0; cyc(1);
        prog_sel = 2'd0; prog_value = 4'd0; cyc(1);
        prog_sel = 2'd3; prog_value = 4'd5; cyc(1);
        reprogram = 1'b0;
        wait_obs(ok);
        sensor[0] = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL zero_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    task automatic test_reset_mid_yellow();
        bit ok, found; seg_t e, o; int n = 0;
        apply_reset();
        cyc(3); sensor[2] = 1'b1; cyc(1); sensor[2] = 1'b0;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            cyc(1);
            found = (yellow[2] === 1'b1);
        end
        checks++; if (!found) begin errors++; $display("FAIL midrst_y2_seen got=0 want=1"); end
        walk_request = 1'b1; sensor[3] = 1'b1; cyc(1);
        walk_request = 1'b0; sensor[3] = 1'b0;
        reset = 1'b1; obs_q.delete(); exp_q.delete();
        cyc(1);
        checks++; if (green !== 4'b0001) begin errors++; $display("FAIL midrst_green got=%b want=0001", green); end
        checks++; if (walk !== 1'b0) begin errors++; $display("FAIL midrst_walk got=%b want=0", walk); end
        checks++; if (yellow !== 4'b0000) begin errors++; $display("FAIL midrst_yellow got=%b want=0000", yellow); end
        checks++; if (cur_phase !== 2'd0) begin errors++; $display("FAIL midrst_phase got=%0d want=0", cur_phase); end
        reset = 1'b0;
        push_exp(sg(0), 24); push_exp(sy(0), 8); push_exp(sar(), 4); push_exp(sg(0), 24);
        wait_obs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got=%0d want=%0d segs", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL midrst_seg%0d got sig=%h len=%0d want sig=%h len=%0d", n, o.sig, o.len, e.sig, e.len); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_cycle();
        test_skip();
        test_extension();
        test_walk();
        test_reprogram();
        test_prog_zero();
        test_reset_mid_yellow();
        started = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
